// File: rtl/alu_result_queue.sv
// alu_result_queue: FIFO holding integer-ALU results (physical destination tag
// and 32-bit value) until the CDB arbiter grants a broadcast slot.
// Optional macro ALU_RQ_BYPASS_EN: lets a result arriving at an empty queue
// reach the outputs in the same cycle and skip storage when granted at once.
//
// Handshake: a transfer happens on a rising edge when valid and ready are both
// high in the cycle before it. Upstream, in_valid && in_ready enqueues, and
// in_ready depends only on registered occupancy. Downstream, out_valid &&
// cdb_grant dequeues, and a grant with out_valid low is ignored. squash
// discards everything, including any same-cycle transfer. reset overrides squash.

`ifndef PHYS_REG_BITS
`define PHYS_REG_BITS 6
`endif

module alu_result_queue #(
    parameter int DEPTH    = 4,
    parameter int CNT_BITS = $clog2(DEPTH) + 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      squash,
    input  logic                      in_valid,
    input  logic [`PHYS_REG_BITS-1:0] in_dest_tag,
    input  logic [31:0]               in_value,
    output logic                      in_ready,
    input  logic                      cdb_grant,
    output logic                      out_valid,
    output logic [`PHYS_REG_BITS-1:0] out_dest_tag,
    output logic [31:0]               out_value,
    output logic [CNT_BITS-1:0]       count
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);

    // Entry storage; contents are don't-care outside the occupied window.
    logic [`PHYS_REG_BITS-1:0] tag_q [DEPTH];
    logic [31:0]               value_q [DEPTH];

    logic [PTR_BITS-1:0] head_q, head_d;
    logic [PTR_BITS-1:0] tail_q, tail_d;
    logic [CNT_BITS-1:0] count_q, count_d;

    logic stored_valid;
    logic bypass_take;
    logic enq;
    logic deq;

    assign stored_valid = (count_q != '0);
    assign in_ready     = (count_q != FULL_CNT);
    assign count        = count_q;

`ifdef ALU_RQ_BYPASS_EN
    logic bypass_hit;

    // A result arriving at an empty queue is offered to the CDB directly.
    assign bypass_hit  = !stored_valid && in_valid && !squash && !reset;
    // Granted in the same cycle: consumed without ever being stored.
    assign bypass_take = bypass_hit && cdb_grant;

    // Head entry when one is stored, otherwise the bypassed input, otherwise 0.
    always_comb begin
        out_valid    = 1'b0;
        out_dest_tag = '0;
        out_value    = '0;
        if (stored_valid) begin
            out_valid    = 1'b1;
            out_dest_tag = tag_q[head_q];
            out_value    = value_q[head_q];
        end else if (bypass_hit) begin
            out_valid    = 1'b1;
            out_dest_tag = in_dest_tag;
            out_value    = in_value;
        end
    end
`else
    assign bypass_take = 1'b0;

    // Head entry when valid, zeros when the queue is empty.
    always_comb begin
        out_valid    = stored_valid;
        out_dest_tag = '0;
        out_value    = '0;
        if (stored_valid) begin
            out_dest_tag = tag_q[head_q];
            out_value    = value_q[head_q];
        end
    end
`endif

    // Dequeue only stored entries; a bypassed result never occupies a slot.
    assign enq = in_valid && in_ready && !bypass_take;
    assign deq = cdb_grant && stored_valid;

    // Next pointer and occupancy values for the normal (non-squash) case.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) begin
            tail_d = tail_q + PTR_BITS'(1);
        end
        if (deq) begin
            head_d = head_q + PTR_BITS'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_BITS'(1);
            2'b01:   count_d = count_q - CNT_BITS'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/occupancy registers: reset beats squash beats normal traffic.
    always_ff @(posedge clock) begin
        if (reset || squash) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Write the arriving result at the tail; storage itself needs no reset.
    always_ff @(posedge clock) begin
        if (enq && !squash && !reset) begin
            tag_q[tail_q]   <= in_dest_tag;
            value_q[tail_q] <= in_value;
        end
    end

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed bench for alu_result_queue (DEPTH=4). Inputs are driven 1 time
// unit after each rising edge; outputs are sampled before the next edge.

`ifndef PHYS_REG_BITS
`define PHYS_REG_BITS 6
`endif

module tb_alu_result_queue;

    localparam int DEPTH    = 4;
    localparam int CNT_BITS = $clog2(DEPTH) + 1;
    localparam int TW       = `PHYS_REG_BITS;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                reset;
    logic                squash;
    logic                in_valid;
    logic [TW-1:0]       in_dest_tag;
    logic [31:0]         in_value;
    logic                in_ready;
    logic                cdb_grant;
    logic                out_valid;
    logic [TW-1:0]       out_dest_tag;
    logic [31:0]         out_value;
    logic [CNT_BITS-1:0] count;

    alu_result_queue #(.DEPTH(DEPTH), .CNT_BITS(CNT_BITS)) dut (
        .clock        (clock),
        .reset        (reset),
        .squash       (squash),
        .in_valid     (in_valid),
        .in_dest_tag  (in_dest_tag),
        .in_value     (in_value),
        .in_ready     (in_ready),
        .cdb_grant    (cdb_grant),
        .out_valid    (out_valid),
        .out_dest_tag (out_dest_tag),
        .out_value    (out_value),
        .count        (count)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [TW+31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        reset       = 1'b0;
        squash      = 1'b0;
        in_valid    = 1'b0;
        in_dest_tag = '0;
        in_value    = '0;
        cdb_grant   = 1'b0;
    endtask

    task automatic drive_in(input logic v, input int tag, input logic [31:0] val);
        in_valid    = v;
        in_dest_tag = TW'(tag);
        in_value    = val;
    endtask

    task automatic check_head(input string tag, input int exp_tag, input logic [31:0] exp_val);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_tag"}, 32'(out_dest_tag), 32'(exp_tag));
        check({tag, "_value"}, out_value, exp_val);
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_tag"}, 32'(out_dest_tag), 32'd0);
        check({tag, "_out_value"}, out_value, 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        drive_idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        check_empty("reset");

        // Fill to DEPTH with tags 5..8, no grant.
        for (int i = 0; i < 4; i++) begin
            drive_in(1'b1, 5 + i, 32'h11 * (i + 1));
            step();
        end
        drive_in(1'b1, 9, 32'h99);
        #1;
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check_head("full_head", 5, 32'h11);
        step();
        check("full_reject_count", 32'(count), 32'd4);
        drive_in(1'b0, 0, 32'h0);

        // Drain in order 5,6,7,8.
        cdb_grant = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_head($sformatf("drain%0d", i), 5 + i, 32'h11 * (i + 1));
            step();
        end
        cdb_grant = 1'b0;
        #1;
        check_empty("drained");

        // Two entries resident, then enqueue + grant every cycle for 10 cycles.
        for (int i = 0; i < 2; i++) begin
            drive_in(1'b1, 1 + i, 32'h101 + 32'(i));
            exp_q.push_back({TW'(1 + i), 32'h101 + 32'(i)});
            step();
        end
        cdb_grant = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic [TW+31:0] e;
            drive_in(1'b1, 3 + i, 32'h200 + 32'(i));
            exp_q.push_back({TW'(3 + i), 32'h200 + 32'(i)});
            #1;
            e = exp_q.pop_front();
            check_head($sformatf("wrap%0d", i), int'(e[TW+31:32]), e[31:0]);
            step();
            check($sformatf("wrap%0d_count", i), 32'(count), 32'd2);
        end
        drive_in(1'b0, 0, 32'h0);
        while (exp_q.size() > 0) begin
            logic [TW+31:0] e;
            e = exp_q.pop_front();
            #1;
            check_head("wrap_tail", int'(e[TW+31:32]), e[31:0]);
            step();
        end
        cdb_grant = 1'b0;
        #1;
        check_empty("wrap_done");

        // Three entries, then squash together with enqueue and grant.
        for (int i = 0; i < 3; i++) begin
            drive_in(1'b1, 1 + i, 32'h300 + 32'(i));
            step();
        end
        check("pre_squash_count", 32'(count), 32'd3);
        drive_in(1'b1, 10, 32'hAAAA);
        cdb_grant = 1'b1;
        squash    = 1'b1;
        step();
        squash    = 1'b0;
        cdb_grant = 1'b0;
        drive_in(1'b0, 0, 32'h0);
        #1;
        check_empty("squash");
        drive_in(1'b1, 3, 32'hDEAD);
        step();
        drive_in(1'b0, 0, 32'h0);
        #1;
        check("post_squash_count", 32'(count), 32'd1);
        check_head("post_squash_head", 3, 32'hDEAD);
        cdb_grant = 1'b1;
        step();

        // Grant while empty: no underflow.
        step();
        cdb_grant = 1'b0;
        #1;
        check_empty("empty_grant");

        // Reset asserted mid-drain with 2 entries.
        for (int i = 0; i < 2; i++) begin
            drive_in(1'b1, 20 + i, 32'h400 + 32'(i));
            step();
        end
        drive_in(1'b0, 0, 32'h0);
        cdb_grant = 1'b1;
        reset     = 1'b1;
        step();
        reset     = 1'b0;
        cdb_grant = 1'b0;
        #1;
        check_empty("mid_drain_reset");

        // Same-cycle result to an empty queue with grant.
        drive_in(1'b1, 12, 32'hCAFE);
        cdb_grant = 1'b1;
        #1;
`ifdef ALU_RQ_BYPASS_EN
        check_head("bypass_same_cycle", 12, 32'hCAFE);
        step();
        drive_in(1'b0, 0, 32'h0);
        cdb_grant = 1'b0;
        #1;
        check_empty("bypass_after");
`else
        check("nobypass_same_cycle_valid", 32'(out_valid), 32'd0);
        step();
        drive_in(1'b0, 0, 32'h0);
        #1;
        check("nobypass_next_count", 32'(count), 32'd1);
        check_head("nobypass_next", 12, 32'hCAFE);
        step();
        cdb_grant = 1'b0;
        #1;
        check_empty("nobypass_after");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
